// File: rtl/nwc_loader_pkg.sv
// Shared NTT constants and types for the NWC coefficient loader.
// Holds the modulus table, coefficient/word geometry and the loader state encoding.
package nwc_loader_pkg;

  localparam int COEF_W     = 30;
  localparam int WORD_W     = 2 * COEF_W;
  localparam int N          = 4096;
  localparam int WORD_CNT   = N / 2;
  localparam int PAIR_CNT_W = $clog2(N);
  localparam int WORD_CNT_W = $clog2(WORD_CNT);

  typedef logic [COEF_W-1:0]     coef_t;
  typedef logic [WORD_W-1:0]     word_t;
  typedef logic [PAIR_CNT_W-1:0] pair_cnt_t;
  typedef logic [WORD_CNT_W-1:0] word_cnt_t;

  localparam pair_cnt_t LAST_IDX = pair_cnt_t'(N - 1);

  typedef enum logic [1:0] {
    ST_FILL,
    ST_WAIT_READY,
    ST_START,
    ST_BUSY
  } state_t;

  // NTT-friendly primes below 2^30; each has 2N | q-1 for N = 4096.
  function automatic coef_t modulus(input int idx);
    coef_t q;
    case (idx)
      1:       q = 30'd754974721;
      2:       q = 30'd469762049;
      default: q = 30'd998244353;
    endcase
    return q;
  endfunction

endpackage

// File: rtl/nwc_loader_if.sv
// Coefficient stream and NWC-processor side signals of the loader.
interface nwc_loader_if;
  import nwc_loader_pkg::*;

  logic  s_valid;
  logic  s_ready;
  coef_t s_coef_a;
  coef_t s_coef_b;
  logic  nwc_ready;
  logic  nwc_finished;
  word_t data_out0;
  word_t data_out1;
  logic  write_enable;
  logic  start;
  logic  busy;
  logic  range_err;

  modport slave (
    input  s_valid, s_coef_a, s_coef_b, nwc_ready, nwc_finished,
    output s_ready, data_out0, data_out1, write_enable, start, busy, range_err
  );

  modport master (
    output s_valid, s_coef_a, s_coef_b, nwc_ready, nwc_finished,
    input  s_ready, data_out0, data_out1, write_enable, start, busy, range_err
  );

endinterface

// File: rtl/nwc_loader_coef_packer.sv
// Packs consecutive even/odd coefficients of one polynomial into a 60-bit word
// and flags any accepted coefficient that is not reduced modulo q.
module coef_packer
  import nwc_loader_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  load,
  input  logic  odd,
  input  coef_t coef,
  input  coef_t q,
  output word_t word,
  output logic  range_err
);

  coef_t even_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      even_q    <= '0;
      word      <= '0;
      range_err <= 1'b0;
    end else if (load) begin
      if (odd) word   <= {coef, even_q};
      else     even_q <= coef;
      // Out-of-range values are still passed through; only the flag records them.
      if (coef >= q) range_err <= 1'b1;
    end
  end

endmodule

// File: rtl/nwc_loader.sv
// Streams 4096 coefficient pairs into the NWC processor as 2048 packed words,
// then hands over with a start pulse and waits for the computation to finish.
module nwc_loader
  import nwc_loader_pkg::*;
#(
  parameter int MOD_INDEX = 0
) (
  input logic             clk,
  input logic             rst_n,
  nwc_loader_if.slave     bus
);

  localparam coef_t Q = modulus(MOD_INDEX);

  state_t    state;
  pair_cnt_t pair_cnt;
  word_cnt_t word_cnt;
  logic      s_ready_q;
  logic      we_q;
  logic      start_q;
  logic      busy_q;
  logic      err_a;
  logic      err_b;
  logic      xfer;

  assign xfer = bus.s_valid && s_ready_q;

  coef_packer u_pack_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (xfer),
    .odd       (pair_cnt[0]),
    .coef      (bus.s_coef_a),
    .q         (Q),
    .word      (bus.data_out0),
    .range_err (err_a)
  );

  coef_packer u_pack_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (xfer),
    .odd       (pair_cnt[0]),
    .coef      (bus.s_coef_b),
    .q         (Q),
    .word      (bus.data_out1),
    .range_err (err_b)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_FILL;
      pair_cnt  <= '0;
      word_cnt  <= '0;
      s_ready_q <= 1'b0;
      we_q      <= 1'b0;
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      we_q    <= xfer && pair_cnt[0];
      start_q <= 1'b0;
      if (we_q) word_cnt <= word_cnt + 1'b1;
      case (state)
        ST_FILL: begin
          s_ready_q <= 1'b1;
          if (xfer) begin
            pair_cnt <= pair_cnt + 1'b1;
            if (pair_cnt == LAST_IDX) begin
              state     <= ST_WAIT_READY;
              s_ready_q <= 1'b0;
              busy_q    <= 1'b1;
            end
          end
        end
        // The final write_enable is already on the bus here, so START lands after it.
        ST_WAIT_READY: begin
          if (bus.nwc_ready) begin
            state   <= ST_START;
            start_q <= 1'b1;
          end
        end
        ST_START: state <= ST_BUSY;
        ST_BUSY: begin
          if (bus.nwc_finished) begin
            state     <= ST_FILL;
            s_ready_q <= 1'b1;
            busy_q    <= 1'b0;
            pair_cnt  <= '0;
            word_cnt  <= '0;
          end
        end
        default: state <= ST_FILL;
      endcase
    end
  end

  assign bus.s_ready      = s_ready_q;
  assign bus.write_enable = we_q;
  assign bus.start        = start_q;
  assign bus.busy         = busy_q;
  assign bus.range_err    = err_a | err_b;

endmodule

// File: tb/tb_nwc_loader.sv
// Scoreboard bench for nwc_loader: packed words are predicted as pairs are
// accepted and compared as write_enable strobes appear.
module tb_nwc_loader;
  import nwc_loader_pkg::*;

  localparam logic [29:0] Q0 = 30'd998244353;

  typedef struct packed {
    logic [59:0] w0;
    logic [59:0] w1;
  } exp_t;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;
  int   we_total;
  int   start_total;
  int   we_base;
  int   start_base;
  logic [29:0] even_a;
  logic [29:0] even_b;
  exp_t exp_q[$];

  nwc_loader_if bus();

  nwc_loader #(.MOD_INDEX(0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Output monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.write_enable) begin
        we_total++;
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_write", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("data_out0", {4'd0, bus.data_out0}, {4'd0, e.w0});
          chk("data_out1", {4'd0, bus.data_out1}, {4'd0, e.w1});
        end
      end
      if (bus.start) start_total++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pair(input int idx, input logic [29:0] a, input logic [29:0] b);
    int guard;
    guard = 0;
    bus.s_valid  = 1'b1;
    bus.s_coef_a = a;
    bus.s_coef_b = b;
    while (!bus.s_ready && guard < 50) begin
      tick();
      guard++;
    end
    if (!bus.s_ready) begin
      chk("accept_timeout", 64'd0, 64'd1);
      bus.s_valid = 1'b0;
      return;
    end
    tick();
    bus.s_valid = 1'b0;
    if (idx % 2 == 0) begin
      even_a = a;
      even_b = b;
    end else begin
      exp_q.push_back('{w0: {a, even_a}, w1: {b, even_b}});
    end
  endtask

  // mode 0: back-to-back, 1: random idle gaps, 2: a = q at index 7.
  task automatic run_fill(input int mode, input int abort_at);
    logic [29:0] a;
    logic [29:0] b;
    we_base    = we_total;
    start_base = start_total;
    for (int i = 0; i < N; i++) begin
      if (abort_at >= 0 && (we_total - we_base) >= abort_at) return;
      if (mode == 1) begin
        while ($urandom_range(1, 0) == 1) tick();
      end
      a = 30'(i);
      b = 30'(N - 1 - i);
      if (mode == 2 && i == 7) a = Q0;
      if (mode == 0 && i == 2000) bus.nwc_finished = 1'b1;
      send_pair(i, a, b);
      if (mode == 0 && i == 2000) begin
        bus.nwc_finished = 1'b0;
        chk("fin_in_fill_ready", {63'd0, bus.s_ready}, 64'd1);
        chk("fin_in_fill_busy", {63'd0, bus.busy}, 64'd0);
      end
      if (mode == 0 && i == 1) begin
        chk("word0_a", {4'd0, bus.data_out0}, {4'd0, 30'd1, 30'd0});
        chk("word0_b", {4'd0, bus.data_out1}, {4'd0, 30'd4094, 30'd4095});
      end
      if (mode == 2 && i == 6) chk("range_err_pre", {63'd0, bus.range_err}, 64'd0);
      if (mode == 2 && i == 7) chk("range_err_set", {63'd0, bus.range_err}, 64'd1);
    end
  endtask

  task automatic finish_job(input int ready_delay);
    logic bad;
    int   guard;
    tick();
    chk("s_ready_drop", {63'd0, bus.s_ready}, 64'd0);
    chk("busy_set", {63'd0, bus.busy}, 64'd1);
    bad = 1'b0;
    repeat (ready_delay) begin
      tick();
      if (bus.start || bus.s_ready) bad = 1'b1;
    end
    chk("hold_no_start", {63'd0, bad}, 64'd0);
    bus.nwc_ready = 1'b1;
    guard = 0;
    while (!bus.start && guard < 20) begin
      tick();
      guard++;
    end
    chk("start_seen", {63'd0, bus.start}, 64'd1);
    bus.nwc_ready = 1'b0;
    repeat (3) tick();
    chk("start_pulses", 64'(start_total - start_base), 64'd1);
    chk("we_count", 64'(we_total - we_base), 64'd2048);
    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    bus.nwc_finished = 1'b1;
    tick();
    bus.nwc_finished = 1'b0;
    chk("s_ready_after_fin", {63'd0, bus.s_ready}, 64'd1);
    chk("busy_clear", {63'd0, bus.busy}, 64'd0);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_data0"}, {4'd0, bus.data_out0}, 64'd0);
    chk({tag, "_data1"}, {4'd0, bus.data_out1}, 64'd0);
    chk({tag, "_we"}, {63'd0, bus.write_enable}, 64'd0);
    chk({tag, "_start"}, {63'd0, bus.start}, 64'd0);
    chk({tag, "_s_ready"}, {63'd0, bus.s_ready}, 64'd0);
    chk({tag, "_busy"}, {63'd0, bus.busy}, 64'd0);
    chk({tag, "_range_err"}, {63'd0, bus.range_err}, 64'd0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vectors          = 0;
    miscompares      = 0;
    we_total         = 0;
    start_total      = 0;
    we_base          = 0;
    start_base       = 0;
    even_a           = '0;
    even_b           = '0;
    rst_n            = 1'b0;
    bus.s_valid      = 1'b0;
    bus.s_coef_a     = '0;
    bus.s_coef_b     = '0;
    bus.nwc_ready    = 1'b0;
    bus.nwc_finished = 1'b0;

    repeat (3) tick();
    check_outputs_zero("reset");
    rst_n = 1'b1;
    #1;
    chk("s_ready_hold", {63'd0, bus.s_ready}, 64'd0);
    tick();
    chk("s_ready_rise", {63'd0, bus.s_ready}, 64'd1);

    run_fill(0, -1);
    finish_job(100);

    run_fill(1, -1);
    finish_job(3);
    chk("range_err_clean", {63'd0, bus.range_err}, 64'd0);

    run_fill(2, -1);
    chk("range_err_sticky", {63'd0, bus.range_err}, 64'd1);
    finish_job(3);
    chk("range_err_after_job", {63'd0, bus.range_err}, 64'd1);

    run_fill(0, 1000);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("midfill_reset");
    exp_q.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk("s_ready_after_rst", {63'd0, bus.s_ready}, 64'd1);

    run_fill(0, -1);
    finish_job(3);
    chk("range_err_fresh", {63'd0, bus.range_err}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/nwc_loader.md
NWC_LOADER -- requirements
Module: nwc_loader

Interface
REQ-001 Parameter MOD_INDEX, default 0: selects the modulus q used by the downstream NWC processor.
REQ-002 clk  input  1  single clock; all logic rising-edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 s_valid  input  1  coefficient pair valid.
REQ-005 s_ready  output  1  loader accepts a pair this cycle.
REQ-006 s_coef_a  input  30  coefficient of polynomial A, natural order, index 0..4095.
REQ-007 s_coef_b  input  30  coefficient of polynomial B, same index as s_coef_a.
REQ-008 nwc_ready  input  1  NWC processor ready for start.
REQ-009 nwc_finished  input  1  one-cycle pulse at the end of an NWC computation.
REQ-010 data_out0  output  60  packed A word to the NWC processor data_in0.
REQ-011 data_out1  output  60  packed B word to the NWC processor data_in1.
REQ-012 write_enable  output  1  one-cycle strobe per packed word.
REQ-013 start  output  1  one-cycle start pulse to the NWC processor.
REQ-014 busy  output  1  high outside FILL state.
REQ-015 range_err  output  1  sticky: some accepted coefficient was >= q.

Function
REQ-016 States: FILL, WAIT_READY, START, BUSY; reset state FILL.
REQ-017 Handshake: a pair transfers when s_valid && s_ready; s_ready = 1 only in FILL; s_ready does not depend on s_valid.
REQ-018 Packing: even-index pair held in a register; on the odd-index transfer, data_out0 <= {a_odd, a_even} and data_out1 <= {b_odd, b_even}, i.e. even coefficient in [29:0] and odd in [59:30].
REQ-019 write_enable is asserted exactly in the cycle after each odd-index transfer, together with the new data_out0/1; it is 0 otherwise.
REQ-020 data_out0/1 hold their value until the next packed word.
REQ-021 An 11-bit word counter increments on each write_enable; exactly 2048 write_enable pulses are issued per job.
REQ-022 The transfer of coefficient index 4095 moves FILL -> WAIT_READY; s_ready drops in the next cycle, and no further transfers are accepted.
REQ-023 WAIT_READY -> START on the first cycle nwc_ready = 1, never earlier than one cycle after the final write_enable.
REQ-024 start = 1 exactly in the START state, for one cycle; START -> BUSY unconditionally.
REQ-025 BUSY -> FILL on nwc_finished = 1; the pair/word counters are then 0 and the first transfer of the next job is possible in the following cycle.
REQ-026 nwc_finished in any state other than BUSY is ignored.
REQ-027 Range check: each accepted a or b coefficient >= q sets range_err; the coefficient is still written unmodified; range_err clears only on reset.
REQ-028 Idle gaps (s_valid = 0) between or inside pairs are permitted and do not alter the packing or the counts.

Reset
REQ-029 rst_n = 0 asynchronously forces: state FILL, counters 0, held pair 0, data_out0/1 = 0, write_enable = 0, start = 0, s_ready = 0 while asserted, busy = 0, range_err = 0.
REQ-030 s_ready rises in the first cycle after rst_n deasserts.
REQ-031 The NWC processor input address counter has no reset; the system asserts rst_n only while the loader word counter is 0 (between jobs). A reset mid-FILL is an unsupported system fault; the loader itself still returns cleanly to FILL.

Structure
REQ-032 The modulus table indexed by MOD_INDEX, the coefficient width (30), the packed word width (60), N = 4096, and the word count 2048 are defined in the shared NTT package and are not local constants.
REQ-033 The state encoding is a package enum.
REQ-034 A sub-module coef_packer (even/odd pair register plus range compare, one instance per polynomial) is used; the FSM and counters remain in nwc_loader.

Verification
REQ-035 Pairs (a = i, b = 4095 - i) for i = 0..4095, s_valid held high -> 2048 write_enable pulses; word 0 is data_out0 = {30'd1, 30'd0} and data_out1 = {30'd4094, 30'd4095}; start is a single pulse after nwc_ready.
REQ-036 s_valid toggled randomly, 50 %, over the same job -> write_enable word contents are identical to REQ-035 and the total is exactly 2048.
REQ-037 nwc_ready held at 0 for 100 cycles after the fill -> start stays 0, s_ready stays 0; nwc_ready = 1 -> start is high for one cycle; nwc_finished then gives s_ready = 1 in the next cycle.
REQ-038 a = q at index 7 -> range_err = 1 one cycle later and stays set; the word is still written with q in bits [59:30].
REQ-039 rst_n pulsed low at word 1000 -> all outputs are 0 immediately; after release, a full fresh job produces 2048 writes and one start.
REQ-040 nwc_finished pulsed during FILL -> no state change, the count continues.
